core_sequencer: RTL and testbench
=================================

# core_sequencer

Multi-cycle control FSM for the RISC-V core: it sequences instruction fetch, decode, execute, memory access and writeback over a single shared memory port. It sits beside the instruction decoder. The decoder supplies per-instruction ALU and result selects; this block supplies all timing strobes (IR load, PC update, memory request, register-file write). It also traps illegal opcodes and unresponsive memory, and counts retired instructions.

## Interface
- `TIMEOUT`, 16: maximum wait cycles for `mem_ready` in FETCH or MEM; legal range ≥1.
- `CNT_W`, 32: width of the retired-instruction counter.

- `clk`  in  1  core clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  level; 1 = execute instructions, 0 = stop at the next instruction boundary.
- `opcode`  in  7  `instr[6:0]` from the IR; valid from DECODE onward.
- `branch_taken`  in  1  branch compare result from the ALU; sampled in EXEC.
- `mem_ready`  in  1  memory completion, single-cycle pulse or level.
- `ir_load`  out  1  load IR from memory read data.
- `pc_en`  out  1  PC write strobe.
- `pc_src`  out  2  PC select: 0 = PC+4, 1 = PC+imm, 2 = ALU result.
- `mem_req`  out  1  memory request.
- `mem_we`  out  1  memory write (store).
- `addr_sel`  out  1  memory address select: 0 = PC, 1 = ALU result.
- `reg_write`  out  1  register-file write strobe.
- `busy`  out  1  FSM is not in IDLE or HALT.
- `halted`  out  1  FSM is in HALT.
- `illegal`  out  1  sticky flag: an unsupported opcode was seen.
- `bus_err`  out  1  sticky flag: a memory timeout occurred.
- `instret`  out  CNT_W  retired-instruction count.

## Operation
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- Opcode classes:
  - R = 0110011, I = 0010011, LOAD = 0000011, STORE = 0100011, BRANCH = 1100011, JAL = 1101111, JALR = 1100111.
  - Any other value is illegal.
- The opcode is captured into `op_q` on the DECODE cycle. EXEC, MEM and WB use only `op_q`.
- IDLE:
  - All strobes are 0.
  - Go to FETCH when `run`=1.
- FETCH:
  - `mem_req`=1, `addr_sel`=0.
  - When `mem_ready`=1: `ir_load`=1 in the same cycle, next state is DECODE.
- DECODE:
  - Capture `op_q`.
  - Next state is EXEC if the opcode is legal; otherwise HALT, and `illegal` is set.
- EXEC:
  - BRANCH: latch `branch_taken` into `br_q`.
  - Next state is MEM for LOAD/STORE, else WB.
- MEM:
  - `mem_req`=1, `addr_sel`=1, `mem_we`=1 for STORE only.
  - Go to WB on `mem_ready`.
- WB:
  - `pc_en`=1.
  - `pc_src`: 1 for JAL; 2 for JALR; 1 for BRANCH with `br_q`=1; 0 otherwise.
  - `reg_write`=1 for R, I, LOAD, JAL, JALR. `reg_write`=0 for STORE and BRANCH.
  - `instret` increments (wraps modulo 2^CNT_W).
  - Next state is FETCH if `run`=1, else IDLE.
- Timeout:
  - `wait_cnt` clears on entry to FETCH or MEM.
  - It increments on each cycle in FETCH/MEM with `mem_ready`=0.
  - If `mem_ready`=0 while `wait_cnt`=TIMEOUT-1, next state is HALT and `bus_err` is set.
  - `mem_ready` arriving on the TIMEOUT-th cycle still completes normally.
- HALT:
  - All strobes are 0; `halted`=1.
  - Exit only by reset.
- `mem_ready` outside FETCH/MEM is ignored. `branch_taken` outside EXEC is ignored.
- `run` dropping mid-instruction does not abort: the instruction completes through WB, then the FSM enters IDLE.
- Strobe outputs are combinational from state, `op_q`, `br_q` and `mem_ready`. No strobe ever asserts in two consecutive states except `mem_req` during a multi-cycle wait.

## Timing
- Reset (asynchronous, immediate): state IDLE; `op_q`, `br_q`, `wait_cnt`, `illegal`, `bus_err` and `instret` all 0; every output 0.
- Reset asserted during FETCH or MEM drops `mem_req` without waiting for a clock edge.
- Latency with zero-wait memory:
  - R, I, BRANCH, JAL, JALR: 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD, STORE: 5 cycles.
  - Each wait cycle adds 1.
- Back-to-back instructions with `run` held at 1: WB is followed directly by FETCH, with no idle cycle.
- `run` rising in IDLE: FETCH begins on the next cycle.
- `instret` updates on the clock edge that leaves WB, so the new value is visible in the following cycle.

## Test plan
- Reset, `run`=1, R-type (0110011) with `mem_ready` tied to 1 → state sequence FETCH, DECODE, EXEC, WB; `reg_write`=1 and `pc_en`=1 with `pc_src`=0 in cycle 4; `instret`=1.
- LOAD, then STORE, with `mem_ready` delayed 3 cycles in MEM → `mem_req`=1 and `addr_sel`=1 for 4 cycles; `mem_we`=0 for the LOAD and 1 for the STORE; `reg_write` is 1 only for the LOAD; `instret`=2.
- BRANCH with `branch_taken`=1, then with `branch_taken`=0 → `pc_src`=1 then 0 in WB; `reg_write`=0 in both. JAL → `pc_src`=1; JALR → `pc_src`=2, both with `reg_write`=1.
- Opcode 0000000 → HALT after DECODE; `illegal`=1, `halted`=1, no `pc_en`. Toggling `run` has no effect; only `rst_n` low clears the flags.
- TIMEOUT=16, `mem_ready` held 0 in FETCH → HALT after 16 cycles, `bus_err`=1. A second run with `mem_ready`=1 on the 16th wait cycle → DECODE, no error.
- `run` deasserted during EXEC → WB completes and `instret` increments, then IDLE. Separately, `rst_n` pulsed low mid-MEM → `mem_req` drops immediately and all outputs are 0.

Source files
------------

// File: rtl/core_sequencer_if.sv
// Memory-port handshake between the core sequencer and the shared memory.
//   mem_req   : memory request (sequencer -> memory)
//   mem_we    : store (write) qualifier for mem_req
//   addr_sel  : address select, 0 = PC, 1 = ALU result
//   mem_ready : completion from memory, single-cycle pulse or level
interface core_sequencer_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output addr_sel,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  addr_sel,
        output mem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM for the RISC-V core. It sequences
// FETCH/DECODE/EXEC/MEM/WB over a single shared memory port. It traps illegal
// opcodes and memory timeouts into HALT, and it counts retired instructions.
// Ports:
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   run            : level, execute when 1, stop at the next instruction boundary when 0
//   opcode         : instr[6:0] from the IR, captured on DECODE
//   branch_taken   : ALU branch compare, sampled in EXEC
//   mem            : memory handshake (mem_req, mem_we, addr_sel, mem_ready)
//   ir_load        : load IR from memory read data
//   pc_en, pc_src  : PC write strobe and select (0 PC+4, 1 PC+imm, 2 ALU)
//   reg_write      : register-file write strobe
//   busy, halted   : status (not IDLE/HALT; in HALT)
//   illegal        : sticky flag, set on an unsupported opcode
//   bus_err        : sticky flag, set on a memory timeout
//   instret        : retired-instruction counter
module core_sequencer #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    run,
    input  logic [6:0]              opcode,
    input  logic                    branch_taken,
    core_sequencer_if.master        mem,
    output logic                    ir_load,
    output logic                    pc_en,
    output logic [1:0]              pc_src,
    output logic                    reg_write,
    output logic                    busy,
    output logic                    halted,
    output logic                    illegal,
    output logic                    bus_err,
    output logic [CNT_W-1:0]        instret
);

    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [6:0]          op_q, op_d;
    logic                br_q, br_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                illegal_q, illegal_d;
    logic                bus_err_q, bus_err_d;
    logic [CNT_W-1:0]    instret_q, instret_d;

    logic                op_legal;
    logic                wait_expired;

    always_comb begin
        op_legal = 1'b0;
        case (opcode)
            OP_R, OP_I, OP_LOAD, OP_STORE,
            OP_BRANCH, OP_JAL, OP_JALR: op_legal = 1'b1;
            default:                    op_legal = 1'b0;
        endcase
    end

    assign wait_expired = (wait_cnt_q == WAIT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            op_q       <= '0;
            br_q       <= 1'b0;
            wait_cnt_q <= '0;
            illegal_q  <= 1'b0;
            bus_err_q  <= 1'b0;
            instret_q  <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            br_q       <= br_d;
            wait_cnt_q <= wait_cnt_d;
            illegal_q  <= illegal_d;
            bus_err_q  <= bus_err_d;
            instret_q  <= instret_d;
        end
    end

    // wait_cnt only holds a non-zero value while a FETCH/MEM wait is in
    // progress, so it is zero on every entry to FETCH or MEM.
    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        br_d         = br_q;
        wait_cnt_d   = '0;
        illegal_d    = illegal_q;
        bus_err_d    = bus_err_q;
        instret_d    = instret_q;
        ir_load      = 1'b0;
        pc_en        = 1'b0;
        pc_src       = 2'd0;
        reg_write    = 1'b0;
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.addr_sel = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (wait_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_DECODE: begin
                op_d = opcode;
                if (op_legal) begin
                    state_d = S_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_EXEC: begin
                if (op_q == OP_BRANCH) br_d = branch_taken;
                if (op_q == OP_LOAD || op_q == OP_STORE) state_d = S_MEM;
                else                                     state_d = S_WB;
            end
            S_MEM: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
                mem.mem_we   = (op_q == OP_STORE);
                if (mem.mem_ready) begin
                    state_d = S_WB;
                end else if (wait_expired) begin
                    bus_err_d = 1'b1;
                    state_d   = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            S_WB: begin
                pc_en = 1'b1;
                case (op_q)
                    OP_JAL:    pc_src = 2'd1;
                    OP_JALR:   pc_src = 2'd2;
                    OP_BRANCH: pc_src = br_q ? 2'd1 : 2'd0;
                    default:   pc_src = 2'd0;
                endcase
                reg_write = (op_q != OP_STORE) && (op_q != OP_BRANCH);
                instret_d = instret_q + 1'b1;
                state_d   = run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy    = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted  = (state_q == S_HALT);
    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign instret = instret_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer. A scoreboard queue holds the
// expected writeback strobes for each issued instruction; a monitor pops and
// compares them whenever the DUT asserts pc_en.
module tb_core_sequencer;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    typedef struct {
        logic [1:0] pc_src;
        logic       reg_write;
        logic       mem_we;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        ir_load;
    logic        pc_en;
    logic [1:0]  pc_src;
    logic        reg_write;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic        bus_err;
    logic [31:0] instret;

    int tests = 0;
    int fails = 0;
    exp_t sb[$];

    core_sequencer_if mif ();

    core_sequencer #(
        .TIMEOUT (16),
        .CNT_W   (32)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem          (mif),
        .ir_load      (ir_load),
        .pc_en        (pc_en),
        .pc_src       (pc_src),
        .reg_write    (reg_write),
        .busy         (busy),
        .halted       (halted),
        .illegal      (illegal),
        .bus_err      (bus_err),
        .instret      (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] src, input logic rw, input logic we);
        exp_t e;
        e.pc_src    = src;
        e.reg_write = rw;
        e.mem_we    = we;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: compare store qualifier in MEM and WB strobes on pc_en.
    always @(negedge clk) begin
        if (rst_n) begin
            if (mif.mem_req && mif.addr_sel) begin
                if (sb.size() == 0) chk("sb_empty_mem", 32'd1, 32'd0);
                else                chk("mem_we", 32'(mif.mem_we), 32'(sb[0].mem_we));
            end
            if (pc_en) begin
                if (sb.size() == 0) begin
                    chk("sb_empty_wb", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("wb_pc_src", 32'(pc_src), 32'(e.pc_src));
                    chk("wb_reg_write", 32'(reg_write), 32'(e.reg_write));
                end
            end
        end
    end

    // Runs one instruction starting in FETCH with run=1. fw/mw are wait cycles
    // before mem_ready in FETCH/MEM. Returns cycles through WB and MEM cycles.
    task automatic exec_instr(input logic [6:0] op, input logic br, input int fw,
                              input int mw, output int cyc, output int mcyc);
        int  fcnt;
        bit  done;
        fcnt = 0;
        mcyc = 0;
        done = 1'b0;
        cyc  = 0;
        opcode       = op;
        branch_taken = br;
        for (int i = 0; i < 64 && !done; i++) begin
            if (mif.mem_req && !mif.addr_sel) begin
                mif.mem_ready = (fcnt >= fw);
                fcnt++;
            end else if (mif.mem_req && mif.addr_sel) begin
                mif.mem_ready = (mcyc >= mw);
                mcyc++;
            end else begin
                mif.mem_ready = 1'b0;
            end
            cyc++;
            @(negedge clk);
            if (pc_en) done = 1'b1;
            tick();
        end
        mif.mem_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int mcyc;
        int n;

        rst_n = 1'b0;
        run = 1'b0;
        opcode = '0;
        branch_taken = 1'b0;
        mif.mem_ready = 1'b0;
        repeat (2) tick();

        chk("rst_busy",     32'(busy), 0);
        chk("rst_halted",   32'(halted), 0);
        chk("rst_illegal",  32'(illegal), 0);
        chk("rst_bus_err",  32'(bus_err), 0);
        chk("rst_instret",  instret, 0);
        chk("rst_mem_req",  32'(mif.mem_req), 0);
        chk("rst_pc_en",    32'(pc_en), 0);
        chk("rst_reg_write", 32'(reg_write), 0);

        rst_n = 1'b1;
        tick();
        chk("idle_no_run", 32'(busy), 0);
        run = 1'b1;
        tick();
        chk("fetch_busy", 32'(busy), 1);
        chk("fetch_req",  32'(mif.mem_req), 1);
        chk("fetch_addr", 32'(mif.addr_sel), 0);

        push(2'd0, 1'b1, 1'b0);
        exec_instr(OP_R, 1'b0, 0, 0, cyc, mcyc);
        chk("r_latency", cyc, 4);
        chk("r_instret", instret, 1);
        chk("b2b_fetch", 32'(mif.mem_req & ~mif.addr_sel), 1);

        push(2'd0, 1'b1, 1'b0);
        exec_instr(OP_LOAD, 1'b0, 0, 3, cyc, mcyc);
        chk("load_latency", cyc, 8);
        chk("load_mem_cycles", mcyc, 4);
        push(2'd0, 1'b0, 1'b1);
        exec_instr(OP_STORE, 1'b0, 0, 3, cyc, mcyc);
        chk("store_latency", cyc, 8);
        chk("store_mem_cycles", mcyc, 4);
        chk("ls_instret", instret, 3);

        push(2'd1, 1'b0, 1'b0);
        exec_instr(OP_BRANCH, 1'b1, 0, 0, cyc, mcyc);
        chk("br_t_latency", cyc, 4);
        push(2'd0, 1'b0, 1'b0);
        exec_instr(OP_BRANCH, 1'b0, 0, 0, cyc, mcyc);
        push(2'd1, 1'b1, 1'b0);
        exec_instr(OP_JAL, 1'b1, 0, 0, cyc, mcyc);
        push(2'd2, 1'b1, 1'b0);
        exec_instr(OP_JALR, 1'b0, 0, 0, cyc, mcyc);
        chk("jalr_latency", cyc, 4);
        push(2'd0, 1'b1, 1'b0);
        exec_instr(OP_I, 1'b1, 2, 0, cyc, mcyc);
        chk("i_fetch_wait_latency", cyc, 6);
        chk("mix_instret", instret, 8);

        // run drops in EXEC: instruction completes, then IDLE
        push(2'd0, 1'b1, 1'b0);
        opcode = OP_R;
        mif.mem_ready = 1'b1;
        tick();
        mif.mem_ready = 1'b0;
        tick();
        run = 1'b0;
        tick();
        chk("rundrop_wb", 32'(pc_en), 1);
        tick();
        chk("rundrop_idle", 32'(busy), 0);
        chk("rundrop_instret", instret, 9);
        tick();
        chk("rundrop_stay_idle", 32'(mif.mem_req), 0);

        // illegal opcode traps to HALT
        run = 1'b1;
        tick();
        opcode = 7'b0000000;
        mif.mem_ready = 1'b1;
        tick();
        mif.mem_ready = 1'b0;
        tick();
        chk("ill_halted",  32'(halted), 1);
        chk("ill_flag",    32'(illegal), 1);
        chk("ill_busy",    32'(busy), 0);
        chk("ill_no_pc_en", 32'(pc_en), 0);
        run = 1'b0;
        tick();
        run = 1'b1;
        repeat (3) tick();
        chk("ill_run_toggle_halted", 32'(halted), 1);
        chk("ill_run_toggle_req", 32'(mif.mem_req), 0);
        chk("ill_instret_kept", instret, 9);
        rst_n = 1'b0;
        #1;
        chk("ill_reset_flag", 32'(illegal), 0);
        chk("ill_reset_halted", 32'(halted), 0);
        chk("ill_reset_instret", instret, 0);
        chk("sb_drained", sb.size(), 0);
        sb.delete();

        // fetch timeout
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("tmo_fetch", 32'(mif.mem_req), 1);
        n = 0;
        while (!halted && n < 40) begin
            tick();
            n++;
        end
        chk("tmo_cycles", n, 16);
        chk("tmo_bus_err", 32'(bus_err), 1);
        chk("tmo_illegal", 32'(illegal), 0);
        chk("tmo_req_off", 32'(mif.mem_req), 0);
        rst_n = 1'b0;
        #1;
        chk("tmo_reset", 32'(bus_err), 0);

        // mem_ready on the 16th wait cycle still completes
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        repeat (15) tick();
        chk("edge_still_fetch", 32'(mif.mem_req), 1);
        push(2'd0, 1'b1, 1'b0);
        opcode = OP_R;
        mif.mem_ready = 1'b1;
        #1;
        chk("edge_ir_load", 32'(ir_load), 1);
        tick();
        mif.mem_ready = 1'b0;
        chk("edge_no_halt", 32'(halted), 0);
        chk("edge_no_bus_err", 32'(bus_err), 0);
        chk("edge_decode_busy", 32'(busy), 1);
        repeat (3) tick();
        chk("edge_instret", instret, 1);

        // reset pulsed mid-MEM drops mem_req immediately
        push(2'd0, 1'b1, 1'b0);
        opcode = OP_LOAD;
        mif.mem_ready = 1'b1;
        tick();
        mif.mem_ready = 1'b0;
        tick();
        tick();
        chk("mid_mem_req", 32'(mif.mem_req & mif.addr_sel), 1);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("rst_mem_req_drop", 32'(mif.mem_req), 0);
        chk("rst_mem_addr", 32'(mif.addr_sel), 0);
        chk("rst_mem_busy", 32'(busy), 0);
        chk("rst_mem_instret", instret, 0);
        chk("rst_mem_reg_write", 32'(reg_write), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
